// File: rtl/au_norm_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : au_norm_iter_pkg
// Purpose  : Shared definitions for the iterative leading-zero normalizer.
//            Holds the FSM state encodings used by au_norm_iter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package au_norm_iter_pkg;

  localparam logic [1:0] c_IDLE_ENC  = 2'd0;
  localparam logic [1:0] c_SHIFT_ENC = 2'd1;
  localparam logic [1:0] c_DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = c_IDLE_ENC,
    SHIFT = c_SHIFT_ENC,
    DONE  = c_DONE_ENC
  } state_e;

endpackage : au_norm_iter_pkg
`default_nettype wire

// File: rtl/au_norm_iter_step.sv
`default_nettype none
// ============================================================================
// Module   : au_norm_iter_step
// Purpose  : Combinational single-iteration step of the normalizer. Given the
//            working value it produces the value after one SHIFT cycle and
//            the amount added to the shift count.
// Ports    : val_i     - current working value
//            next_o    - working value after this iteration's shift
//            inc_o     - shift amount applied (1 or STEP)
//            msb_set_o - working value is already normalized
// Revision : 1.0 - initial release
// ============================================================================
module au_norm_iter_step
  import au_norm_iter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int STEP  = 1,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] next_o,
  output logic [CW-1:0]    inc_o,
  output logic             msb_set_o
);

  assign msb_set_o = val_i[WIDTH-1];

  if (STEP > 1) begin : g_multi
    // A wide shift is only safe when every bit it discards is zero;
    // otherwise fall back to single-bit steps so the MSB lands exactly.
    logic w_top_zero;
    assign w_top_zero = (val_i[WIDTH-1 -: STEP] == '0);
    assign next_o     = w_top_zero ? (val_i << STEP) : (val_i << 1);
    assign inc_o      = w_top_zero ? CW'(STEP) : CW'(1);
  end else begin : g_single
    assign next_o = val_i << 1;
    assign inc_o  = CW'(1);
  end

endmodule : au_norm_iter_step
`default_nettype wire

// File: rtl/au_norm_iter.sv
`default_nettype none
// ============================================================================
// Module   : au_norm_iter
// Purpose  : Iterative normalizer. Shifts an operand left until its MSB is
//            set, reporting the shift count (leading-zero count) and a flag
//            for an all-zero operand. One operation in flight, valid/ready
//            handshakes on both sides.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            in_valid/in_ready/a - operand handshake and data
//            out_valid/out_ready - result handshake
//            z, cnt, zero        - normalized value, shift count, zero flag
// Revision : 1.0 - initial release
// ============================================================================
module au_norm_iter
  import au_norm_iter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int STEP  = 1,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [CW-1:0]    cnt,
  output logic             zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] step_next;
  logic [CW-1:0]    step_inc;
  logic             step_msb;

  au_norm_iter_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .val_i     (work_q),
    .next_o    (step_next),
    .inc_o     (step_inc),
    .msb_set_o (step_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = a;
          if (a == '0) begin
            // Nothing to shift: report the full width immediately.
            cnt_d   = CW'(WIDTH);
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            zero_d  = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (step_msb) begin
          state_d = DONE;
        end else begin
          work_d = step_next;
          cnt_d  = cnt_q + step_inc;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Gated by rst so no operand is offered while reset is held.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign z         = work_q;
  assign cnt       = cnt_q;
  assign zero      = zero_q;

endmodule : au_norm_iter
`default_nettype wire

// File: tb/tb_au_norm_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_au_norm_iter
// Purpose  : Self-checking bench for au_norm_iter. Three instances cover
//            STEP = 1, 4 and 8 (= WIDTH) at WIDTH = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_au_norm_iter;

  localparam int c_W  = 8;
  localparam int c_CW = 4;

  logic            clk;
  logic            rst;
  logic [2:0]      in_valid_t;
  logic [2:0]      in_ready_t;
  logic [2:0]      out_valid_t;
  logic [2:0]      out_ready_t;
  logic [2:0]      zero_t;
  logic [c_W-1:0]  a_t   [3];
  logic [c_W-1:0]  z_t   [3];
  logic [c_CW-1:0] cnt_t [3];

  int n_cmp;
  int n_err;

  au_norm_iter #(.WIDTH(c_W), .STEP(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_t[0]), .in_ready(in_ready_t[0]),
    .a(a_t[0]), .out_valid(out_valid_t[0]), .out_ready(out_ready_t[0]),
    .z(z_t[0]), .cnt(cnt_t[0]), .zero(zero_t[0])
  );

  au_norm_iter #(.WIDTH(c_W), .STEP(4)) u_dut_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_t[1]), .in_ready(in_ready_t[1]),
    .a(a_t[1]), .out_valid(out_valid_t[1]), .out_ready(out_ready_t[1]),
    .z(z_t[1]), .cnt(cnt_t[1]), .zero(zero_t[1])
  );

  au_norm_iter #(.WIDTH(c_W), .STEP(8)) u_dut_s8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_t[2]), .in_ready(in_ready_t[2]),
    .a(a_t[2]), .out_valid(out_valid_t[2]), .out_ready(out_ready_t[2]),
    .z(z_t[2]), .cnt(cnt_t[2]), .zero(zero_t[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int step_of(input int sel);
    if (sel == 0) return 1;
    if (sel == 1) return 4;
    return 8;
  endfunction

  // Reference: leading zeros counted bit by bit from the MSB.
  function automatic int lz_of(input logic [c_W-1:0] v);
    int n = 0;
    for (int b = c_W - 1; b >= 0; b--) begin
      if (v[b]) return n;
      n++;
    end
    return n;
  endfunction

  // One full operation: accept, wait for the result, hold it for 'hold'
  // cycles with out_ready low (0 = out_ready high in advance), then drain.
  task automatic run_op(input int sel, input logic [c_W-1:0] av, input int hold,
                        input logic [c_W-1:0] ez, input int ec, input logic ezero,
                        input int elat, input string tag);
    int k;
    @(negedge clk);
    chk({tag, "/in_ready"}, 32'(in_ready_t[sel]), 32'd1);
    a_t[sel]         = av;
    in_valid_t[sel]  = 1'b1;
    out_ready_t[sel] = (hold == 0);
    @(negedge clk);
    // Garbage offered while busy must be ignored.
    a_t[sel] = ~av;
    k = 1;
    while (!out_valid_t[sel] && k < 40) begin
      @(negedge clk);
      k++;
    end
    in_valid_t[sel] = 1'b0;
    chk({tag, "/latency"}, 32'(k), 32'(elat));
    chk({tag, "/z"}, 32'(z_t[sel]), 32'(ez));
    chk({tag, "/cnt"}, 32'(cnt_t[sel]), 32'(ec));
    chk({tag, "/zero"}, 32'(zero_t[sel]), 32'(ezero));
    chk({tag, "/busy"}, 32'(in_ready_t[sel]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "/hold_valid"}, 32'(out_valid_t[sel]), 32'd1);
      chk({tag, "/hold_z"}, 32'(z_t[sel]), 32'(ez));
      chk({tag, "/hold_cnt"}, 32'(cnt_t[sel]), 32'(ec));
      chk({tag, "/hold_busy"}, 32'(in_ready_t[sel]), 32'd0);
    end
    out_ready_t[sel] = 1'b1;
    @(negedge clk);
    out_ready_t[sel] = 1'b0;
    chk({tag, "/drained"}, 32'(out_valid_t[sel]), 32'd0);
    chk({tag, "/idle"}, 32'(in_ready_t[sel]), 32'd1);
  endtask

  initial begin
    logic [c_W-1:0] rv;
    int             lz;
    int             seen;
    n_cmp = 0;
    n_err = 0;
    rst         = 1'b1;
    in_valid_t  = '0;
    out_ready_t = '0;
    for (int i = 0; i < 3; i++) a_t[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst/in_ready", 32'(in_ready_t[0]), 32'd0);
    chk("rst/out_valid", 32'(out_valid_t[0]), 32'd0);
    chk("rst/z", 32'(z_t[0]), 32'd0);
    chk("rst/cnt", 32'(cnt_t[0]), 32'd0);
    chk("rst/zero", 32'(zero_t[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst/ready_after", 32'(in_ready_t[0]), 32'd1);

    // STEP = 1
    run_op(0, 8'b0001_0110, 0, 8'b1011_0000, 3, 1'b0, 5, "s1_16");
    run_op(0, 8'h00, 1, 8'h00, 8, 1'b1, 1, "s1_zero");
    run_op(0, 8'h80, 3, 8'h80, 0, 1'b0, 2, "s1_80");
    run_op(0, 8'h01, 0, 8'h80, 7, 1'b0, 9, "s1_01");
    // STEP = 4: lz/4 wide shifts, lz%4 single shifts, +2
    run_op(1, 8'b0000_0011, 0, 8'b1100_0000, 6, 1'b0, 5, "s4_03");
    run_op(1, 8'h01, 2, 8'h80, 7, 1'b0, 6, "s4_01");
    run_op(1, 8'h0F, 0, 8'hF0, 4, 1'b0, 3, "s4_0F");
    run_op(1, 8'h20, 0, 8'h80, 2, 1'b0, 4, "s4_20");
    run_op(1, 8'h00, 0, 8'h00, 8, 1'b1, 1, "s4_zero");
    // STEP = WIDTH: only an all-zero operand could take the wide shift
    run_op(2, 8'h05, 1, 8'hA0, 5, 1'b0, 7, "s8_05");
    run_op(2, 8'hFF, 0, 8'hFF, 0, 1'b0, 2, "s8_FF");

    // Reset mid-SHIFT aborts the operation
    @(negedge clk);
    a_t[0]         = 8'h01;
    in_valid_t[0]  = 1'b1;
    out_ready_t[0] = 1'b1;
    @(negedge clk);
    in_valid_t[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort/in_ready", 32'(in_ready_t[0]), 32'd0);
    chk("abort/out_valid", 32'(out_valid_t[0]), 32'd0);
    chk("abort/z", 32'(z_t[0]), 32'd0);
    chk("abort/cnt", 32'(cnt_t[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready_t[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid_t[0]) seen++;
    end
    chk("abort/no_result", 32'(seen), 32'd0);
    run_op(0, 8'h40, 0, 8'h80, 1, 1'b0, 3, "after_abort");

    // Randomised operands with back-pressure, checked against the model
    for (int sel = 0; sel < 3; sel++) begin
      for (int n = 0; n < 60; n++) begin
        rv = 8'($urandom_range(0, 255) >> $urandom_range(0, 8));
        lz = lz_of(rv);
        run_op(sel, rv, $urandom_range(0, 2), 8'(rv << lz), lz, (rv == '0),
               (rv == '0) ? 1 : (lz / step_of(sel) + lz % step_of(sel) + 2),
               $sformatf("rnd_s%0d_%0d", step_of(sel), n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_au_norm_iter
`default_nettype wire
